// File: rtl/fir_filter_pkg.sv
// -----------------------------------------------------------------------------
// fir_filter_pkg
//
// Shared definitions for the FIR accumulator bank:
//   - ovf_mode_e      : overflow handling mode (WRAP / SAT)
//   - signed_max/min  : two's-complement extremes for a given width, returned
//                       in a MAX_WIDTH container (callers keep the low bits)
//   - calc_ch_w       : channel index width, max(1, clog2(num_channels))
//   - mode_from_param : maps the integer SATURATE parameter onto ovf_mode_e
// -----------------------------------------------------------------------------
package fir_filter_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } ovf_mode_e;

    // Widest sample the helper functions can describe.
    localparam int MAX_WIDTH = 64;

    // 0111...1 in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // 1000...0 in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i == width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // A single channel still needs a 1-bit index port.
    function automatic int calc_ch_w(input int num_channels);
        return (num_channels <= 2) ? 1 : $clog2(num_channels);
    endfunction

    function automatic ovf_mode_e mode_from_param(input int saturate);
        return (saturate != 0) ? SAT : WRAP;
    endfunction

endpackage

// File: rtl/fir_filter_sat_adder.sv
// -----------------------------------------------------------------------------
// fir_filter_sat_adder
//
// Combinational signed adder for one accumulation step.
//   a         : current accumulator value
//   b         : incoming product
//   overwrite : pass b through unchanged (first tap), never flags overflow
//   saturate  : 1 = clamp an overflowing sum, 0 = wrap modulo 2^WIDTH
//   result    : a + b (or b), possibly clamped
//   overflow  : signed overflow of a + b (operands same sign, sum sign differs)
// -----------------------------------------------------------------------------
module fir_filter_sat_adder
    import fir_filter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             overwrite,
    input  logic             saturate,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic [MAX_WIDTH-1:0] MAX_FULL = signed_max(WIDTH);
    localparam logic [MAX_WIDTH-1:0] MIN_FULL = signed_min(WIDTH);
    localparam logic [WIDTH-1:0]     POS_MAX  = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     NEG_MIN  = MIN_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] raw_sum;

    assign raw_sum = a + b;

    // NOTE: every output of a combinational block gets a default assignment
    // first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        result   = raw_sum;
        overflow = 1'b0;

        if (overwrite) begin
            result = b;
        end else begin
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);
            if (overflow && saturate) begin
                // Both operands share a sign, so a's sign tells the direction.
                result = a[WIDTH-1] ? NEG_MIN : POS_MAX;
            end
        end
    end

endmodule

// File: rtl/fir_filter_accum_bank.sv
// -----------------------------------------------------------------------------
// fir_filter_accum_bank
//
// Registered, multi-channel accumulation stage of the FIR filter. Each
// time-interleaved channel owns one accumulator; a first tap overwrites it,
// later taps add to it, and a last tap emits the finished sample one cycle
// later through a valid/ready output register.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   mult_corrected_in     : signed product for this tap
//   channel_in            : target accumulator (out-of-range: consumed, ignored)
//   valid_in              : product valid
//   first_tap_in          : overwrite accumulator instead of adding
//   last_tap_in           : this tap completes the output sample
//   ready_out             : product accepted this cycle when valid_in is high
//   accum_value_out       : completed filter output
//   channel_out           : channel of accum_value_out
//   output_valid_out      : result valid
//   output_ready_in       : downstream accepts result
//   overflow_out          : overflow in any tap of the presented result
//   overflow_sticky_out   : per-channel sticky overflow status
//   clear_sticky_in       : clear all sticky bits (a same-cycle set wins)
// -----------------------------------------------------------------------------
module fir_filter_accum_bank
    import fir_filter_pkg::*;
#(
    parameter  int OUTPUT_WIDTH = 32,
    parameter  int NUM_CHANNELS = 4,
    parameter  int SATURATE     = 1,
    localparam int CH_W         = calc_ch_w(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OUTPUT_WIDTH-1:0] mult_corrected_in,
    input  logic [CH_W-1:0]         channel_in,
    input  logic                    valid_in,
    input  logic                    first_tap_in,
    input  logic                    last_tap_in,
    output logic                    ready_out,
    output logic [OUTPUT_WIDTH-1:0] accum_value_out,
    output logic [CH_W-1:0]         channel_out,
    output logic                    output_valid_out,
    input  logic                    output_ready_in,
    output logic                    overflow_out,
    output logic [NUM_CHANNELS-1:0] overflow_sticky_out,
    input  logic                    clear_sticky_in
);

    localparam ovf_mode_e OVF_MODE = mode_from_param(SATURATE);

    logic [OUTPUT_WIDTH-1:0] acc [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pend_ovf;

    logic [NUM_CHANNELS-1:0] ch_hit;
    logic                    ch_valid;
    logic [OUTPUT_WIDTH-1:0] acc_sel;
    logic                    pend_sel;
    logic                    accept;
    logic [OUTPUT_WIDTH-1:0] sum;
    logic                    tap_ovf;
    logic                    result_ovf;

    // A new product may enter whenever the output register is empty or is
    // being drained this very cycle.
    assign ready_out = !output_valid_out || output_ready_in;
    assign accept    = valid_in && ready_out;

    // One-hot channel decode. An index >= NUM_CHANNELS hits nothing, which is
    // what makes out-of-range products vanish without touching any state.
    always_comb begin
        ch_hit   = '0;
        acc_sel  = '0;
        pend_sel = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (channel_in == CH_W'(i)) begin
                ch_hit[i] = 1'b1;
                acc_sel   = acc[i];
                pend_sel  = pend_ovf[i];
            end
        end
    end

    assign ch_valid = |ch_hit;

    fir_filter_sat_adder #(
        .WIDTH (OUTPUT_WIDTH)
    ) u_sat_adder (
        .a         (acc_sel),
        .b         (mult_corrected_in),
        .overwrite (first_tap_in),
        .saturate  (OVF_MODE == SAT),
        .result    (sum),
        .overflow  (tap_ovf)
    );

    // Overflow history for the sample in flight; a first tap starts it afresh.
    assign result_ovf = (first_tap_in ? 1'b0 : pend_sel) | tap_ovf;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the accumulator array is reset explicitly because a reset
            // must discard partial sums; a later non-first tap would otherwise
            // add onto stale data.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                acc[i] <= '0;
            end
            pend_ovf            <= '0;
            overflow_sticky_out <= '0;
            output_valid_out    <= 1'b0;
            accum_value_out     <= '0;
            channel_out         <= '0;
            overflow_out        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (accept && ch_hit[i]) begin
                    acc[i]      <= sum;
                    pend_ovf[i] <= result_ovf;
                end

                // Set has priority over a simultaneous clear.
                if (accept && ch_hit[i] && tap_ovf) begin
                    overflow_sticky_out[i] <= 1'b1;
                end else if (clear_sticky_in) begin
                    overflow_sticky_out[i] <= 1'b0;
                end
            end

            // A last-tap accept can only happen with ready_out high, so it
            // either fills an empty register or replaces one being drained.
            if (accept && ch_valid && last_tap_in) begin
                accum_value_out  <= sum;
                channel_out      <= channel_in;
                overflow_out     <= result_ovf;
                output_valid_out <= 1'b1;
            end else if (output_valid_out && output_ready_in) begin
                output_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_accum_bank.sv
module tb_fir_filter_accum_bank;

    localparam int W          = 32;
    localparam int N          = 4;
    localparam int CH_W       = 2;
    localparam int CLK_HALF   = 5;
    localparam int WAIT_LIMIT = 50;

    typedef struct packed {
        logic [W-1:0]    value;
        logic [CH_W-1:0] ch;
        logic            ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    mult_corrected_in;
    logic [CH_W-1:0] channel_in;
    logic            valid_in;
    logic            first_tap_in;
    logic            last_tap_in;
    logic            output_ready_in;
    logic            clear_sticky_in;

    // Saturating instance (scoreboarded)
    logic            ready_out;
    logic [W-1:0]    accum_value_out;
    logic [CH_W-1:0] channel_out;
    logic            output_valid_out;
    logic            overflow_out;
    logic [N-1:0]    overflow_sticky_out;

    // Wrapping instance (same stimulus, checked inline)
    logic            w_ready_out;
    logic [W-1:0]    w_accum_value_out;
    logic [CH_W-1:0] w_channel_out;
    logic            w_output_valid_out;
    logic            w_overflow_out;
    logic [N-1:0]    w_overflow_sticky_out;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    exp_t mon_exp;

    fir_filter_accum_bank #(
        .OUTPUT_WIDTH (W),
        .NUM_CHANNELS (N),
        .SATURATE     (1)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mult_corrected_in   (mult_corrected_in),
        .channel_in          (channel_in),
        .valid_in            (valid_in),
        .first_tap_in        (first_tap_in),
        .last_tap_in         (last_tap_in),
        .ready_out           (ready_out),
        .accum_value_out     (accum_value_out),
        .channel_out         (channel_out),
        .output_valid_out    (output_valid_out),
        .output_ready_in     (output_ready_in),
        .overflow_out        (overflow_out),
        .overflow_sticky_out (overflow_sticky_out),
        .clear_sticky_in     (clear_sticky_in)
    );

    fir_filter_accum_bank #(
        .OUTPUT_WIDTH (W),
        .NUM_CHANNELS (N),
        .SATURATE     (0)
    ) dut_wrap (
        .clk                 (clk),
        .rst                 (rst),
        .mult_corrected_in   (mult_corrected_in),
        .channel_in          (channel_in),
        .valid_in            (valid_in),
        .first_tap_in        (first_tap_in),
        .last_tap_in         (last_tap_in),
        .ready_out           (w_ready_out),
        .accum_value_out     (w_accum_value_out),
        .channel_out         (w_channel_out),
        .output_valid_out    (w_output_valid_out),
        .output_ready_in     (output_ready_in),
        .overflow_out        (w_overflow_out),
        .overflow_sticky_out (w_overflow_sticky_out),
        .clear_sticky_in     (clear_sticky_in)
    );

    always #CLK_HALF clk = ~clk;

    // Scoreboard: a result is consumed when valid && ready at the edge ahead.
    always @(negedge clk) begin
        if (!rst && output_valid_out && output_ready_in) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_result: got value=%h ch=%0d ovf=%0b, required no output",
                         accum_value_out, channel_out, overflow_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({accum_value_out, channel_out, overflow_out} !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL scoreboard: got value=%h ch=%0d ovf=%0b, required value=%h ch=%0d ovf=%0b",
                             accum_value_out, channel_out, overflow_out,
                             mon_exp.value, mon_exp.ch, mon_exp.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [W-1:0] v, input int ch, input logic ovf);
        exp_t e;
        e.value = v;
        e.ch    = CH_W'(ch);
        e.ovf   = ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one product and returns #1 after the edge that accepted it.
    task automatic send(input logic [W-1:0] p, input int ch, input logic first, input logic last);
        int cycles;
        bit took;
        mult_corrected_in = p;
        channel_in        = CH_W'(ch);
        first_tap_in      = first;
        last_tap_in       = last;
        valid_in          = 1'b1;
        cycles = 0;
        took   = 1'b0;
        while (!took && cycles < WAIT_LIMIT) begin
            @(negedge clk);
            took = ready_out;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!took) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: product %h on ch %0d not accepted in %0d cycles", p, ch, WAIT_LIMIT);
        end
        valid_in     = 1'b0;
        first_tap_in = 1'b0;
        last_tap_in  = 1'b0;
    endtask

    task automatic drain();
        int cycles;
        cycles = 0;
        while ((exp_q.size() != 0 || output_valid_out) && cycles < WAIT_LIMIT) begin
            idle(1);
            cycles++;
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d results still expected, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        tests_run++;
        if ({output_valid_out, accum_value_out, channel_out, overflow_out, overflow_sticky_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b value=%h ch=%0d ovf=%0b sticky=%b, required all 0",
                     output_valid_out, accum_value_out, channel_out, overflow_out, overflow_sticky_out);
        end
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %0b, required 1", ready_out);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        push_exp(32'd6, 0, 1'b0);
        send(32'd3, 0, 1'b1, 1'b0);
        send(32'd5, 0, 1'b0, 1'b0);
        send(-32'sd2, 0, 1'b0, 1'b1);
        tests_run++;
        if (output_valid_out !== 1'b1 || accum_value_out !== 32'd6) begin
            tests_failed++;
            $display("FAIL basic_latency: got valid=%0b value=%h, required valid=1 value=6",
                     output_valid_out, accum_value_out);
        end
        drain();
    endtask

    task automatic test_overflow();
        // Positive overflow
        push_exp(32'h7FFF_FFFF, 3, 1'b1);
        send(32'h7FFF_FFF0, 3, 1'b1, 1'b0);
        send(32'h0000_0020, 3, 1'b0, 1'b1);
        tests_run++;
        if (w_accum_value_out !== 32'h8000_0010 || w_overflow_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pos: got value=%h ovf=%0b, required value=80000010 ovf=1",
                     w_accum_value_out, w_overflow_out);
        end
        tests_run++;
        if (overflow_sticky_out !== 4'b1000 || w_overflow_sticky_out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL sticky_set: got sat=%b wrap=%b, required 1000",
                     overflow_sticky_out, w_overflow_sticky_out);
        end
        // Negative overflow: 0x80000010 + (-32)
        push_exp(32'h8000_0000, 3, 1'b1);
        send(32'h8000_0010, 3, 1'b1, 1'b0);
        send(32'hFFFF_FFE0, 3, 1'b0, 1'b1);
        tests_run++;
        if (w_accum_value_out !== 32'h7FFF_FFF0 || w_overflow_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_neg: got value=%h ovf=%0b, required value=7ffffff0 ovf=1",
                     w_accum_value_out, w_overflow_out);
        end
        // A first+last tap restarts the overflow history
        push_exp(32'd5, 3, 1'b0);
        send(32'd5, 3, 1'b1, 1'b1);
        tests_run++;
        if (w_overflow_out !== 1'b0 || w_accum_value_out !== 32'd5) begin
            tests_failed++;
            $display("FAIL single_tap_ovf: got value=%h ovf=%0b, required value=5 ovf=0",
                     w_accum_value_out, w_overflow_out);
        end
        drain();
    endtask

    task automatic test_interleave();
        send(32'd10, 1, 1'b1, 1'b0);
        send(32'd7, 2, 1'b1, 1'b0);
        push_exp(32'd11, 1, 1'b0);
        send(32'd1, 1, 1'b0, 1'b1);
        push_exp(32'd0, 2, 1'b0);
        send(-32'sd7, 2, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_stall();
        output_ready_in = 1'b0;
        push_exp(32'd42, 0, 1'b0);
        send(32'd42, 0, 1'b1, 1'b1);
        mult_corrected_in = 32'd7;
        channel_in        = 2'd0;
        first_tap_in      = 1'b1;
        last_tap_in       = 1'b1;
        valid_in          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (ready_out !== 1'b0 || output_valid_out !== 1'b1 || accum_value_out !== 32'd42) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d got ready=%0b valid=%0b value=%h, required ready=0 valid=1 value=2a",
                         i, ready_out, output_valid_out, accum_value_out);
            end
            @(posedge clk);
            #1;
        end
        push_exp(32'd7, 0, 1'b0);
        output_ready_in = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got %0b, required 1", ready_out);
        end
        @(posedge clk);
        #1;
        valid_in     = 1'b0;
        first_tap_in = 1'b0;
        last_tap_in  = 1'b0;
        tests_run++;
        if (output_valid_out !== 1'b1 || accum_value_out !== 32'd7) begin
            tests_failed++;
            $display("FAIL stall_release_load: got valid=%0b value=%h, required valid=1 value=7",
                     output_valid_out, accum_value_out);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [3];
        vals[0] = 32'd4;
        vals[1] = 32'd9;
        vals[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            push_exp(vals[i], 2, 1'b0);
            send(vals[i], 2, 1'b1, 1'b1);
            tests_run++;
            if (output_valid_out !== 1'b1 || accum_value_out !== vals[i]) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got valid=%0b value=%h, required valid=1 value=%h",
                         i, output_valid_out, accum_value_out, vals[i]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        send(32'd100, 0, 1'b1, 1'b0);
        // Leave a result parked in the output register, then reset over it.
        output_ready_in = 1'b0;
        send(32'd55, 1, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        output_ready_in = 1'b1;
        tests_run++;
        if ({output_valid_out, accum_value_out, channel_out, overflow_out, overflow_sticky_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got valid=%0b value=%h ch=%0d ovf=%0b sticky=%b, required all 0",
                     output_valid_out, accum_value_out, channel_out, overflow_out, overflow_sticky_out);
        end
        // Accumulator must restart from 0, not from the discarded 100.
        push_exp(32'd8, 0, 1'b0);
        send(32'd8, 0, 1'b0, 1'b1);
        push_exp(32'd5, 0, 1'b0);
        send(32'd2, 0, 1'b1, 1'b0);
        send(32'd3, 0, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_clear_sticky();
        push_exp(32'h7FFF_FFFF, 1, 1'b1);
        send(32'h7FFF_FFF0, 1, 1'b1, 1'b0);
        clear_sticky_in = 1'b1;
        send(32'h0000_0020, 1, 1'b0, 1'b1);
        clear_sticky_in = 1'b0;
        tests_run++;
        if (overflow_sticky_out !== 4'b0010) begin
            tests_failed++;
            $display("FAIL clear_vs_set: got sticky=%b, required 0010", overflow_sticky_out);
        end
        clear_sticky_in = 1'b1;
        idle(1);
        clear_sticky_in = 1'b0;
        tests_run++;
        if (overflow_sticky_out !== 4'b0000 || w_overflow_sticky_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clear_sticky: got sat=%b wrap=%b, required 0000",
                     overflow_sticky_out, w_overflow_sticky_out);
        end
        drain();
    endtask

    initial begin
        mult_corrected_in = '0;
        channel_in        = '0;
        valid_in          = 1'b0;
        first_tap_in      = 1'b0;
        last_tap_in       = 1'b0;
        output_ready_in   = 1'b1;
        clear_sticky_in   = 1'b0;

        test_reset();
        test_basic();
        test_overflow();
        test_interleave();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_clear_sticky();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
